mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Word-addressed data memory access unit with an internal stack pointer.
// Three-cycle request flow: accept in IDLE, perform the access in ACCESS, respond in RESP.
module mem_access_unit #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 1024,
  parameter int STACK_STEP = 2,
  parameter int SP_INIT    = DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              MemWrite,
  input  logic [1:0]        MemSrc,
  input  logic [2:0]        MemDst,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] ze_imm,
  input  logic [DATA_W-1:0] ls_imm,
  input  logic [DATA_W-1:0] MaryData,
  input  logic [DATA_W-1:0] ShelleyData,
  input  logic [DATA_W-1:0] RAData,
  output logic [DATA_W-1:0] mem_out,
  output logic              out_valid,
  output logic              fault,
  output logic [DATA_W-1:0] sp_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W:0]   DEPTH_X   = (DATA_W+1)'(DEPTH);
  localparam logic [DATA_W:0]   STEP_X    = (DATA_W+1)'(STACK_STEP);
  localparam logic [DATA_W:0]   SP_INIT_X = (DATA_W+1)'(SP_INIT);
  localparam logic [DATA_W-1:0] STEP_D    = DATA_W'(STACK_STEP);
  localparam logic [DATA_W-1:0] SP_INIT_D = DATA_W'(SP_INIT);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t            state;
  logic [DATA_W-1:0] sp;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_p0;
  logic [2:0]        dst_p0;
  logic [DATA_W-1:0] pc_p0, ze_p0, ls_p0, wdata_p0;

  logic [DATA_W-1:0] addr_p1, rd_data_p1;
  logic              is_push_p1, is_pop_p1, fault_p1, wr_p1;

  function automatic logic [DATA_W-1:0] sel_wdata(input logic [1:0] src,
                                                  input logic [DATA_W-1:0] mary,
                                                  input logic [DATA_W-1:0] shelley,
                                                  input logic [DATA_W-1:0] ra);
    case (src)
      2'b00:   return mary;
      2'b01:   return shelley;
      2'b10:   return ra;
      default: return '0;
    endcase
  endfunction

  // All address arithmetic wraps modulo 2^DATA_W; range is checked afterwards.
  function automatic logic [DATA_W-1:0] eff_addr(input logic [2:0] dst,
                                                 input logic [DATA_W-1:0] sp_v,
                                                 input logic [DATA_W-1:0] pc_v,
                                                 input logic [DATA_W-1:0] ze_v,
                                                 input logic [DATA_W-1:0] ls_v);
    case (dst)
      3'b000:  return pc_v;
      3'b001:  return ze_v;
      3'b100:  return sp_v + DATA_W'(2);
      3'b101:  return sp_v + ls_v;
      3'b110:  return sp_v - STEP_D;
      3'b111:  return sp_v;
      default: return '0;
    endcase
  endfunction

  function automatic logic stack_fault(input logic push, input logic pop,
                                       input logic [DATA_W-1:0] sp_v);
    return (push && ({1'b0, sp_v} < STEP_X)) ||
           (pop && (({1'b0, sp_v} + STEP_X) > SP_INIT_X));
  endfunction

  // ACCESS stage: decode latched request against the current SP
  always_comb begin
    is_push_p1 = (dst_p0 == 3'b110);
    is_pop_p1  = (dst_p0 == 3'b111);
    addr_p1    = eff_addr(dst_p0, sp, pc_p0, ze_p0, ls_p0);
    fault_p1   = (dst_p0[2:1] == 2'b01) ||
                 ({1'b0, addr_p1} >= DEPTH_X) ||
                 stack_fault(is_push_p1, is_pop_p1, sp);
    wr_p1      = is_push_p1 || (wr_p0 && !is_pop_p1);
    rd_data_p1 = mem[addr_p1[AW-1:0]];
  end

  assign sp_out = sp;

  // IDLE -> ACCESS boundary: capture the request
  always_ff @(posedge clock) begin
    if (req_ready && req_valid) begin
      wr_p0    <= MemWrite;
      dst_p0   <= MemDst;
      pc_p0    <= pc;
      ze_p0    <= ze_imm;
      ls_p0    <= ls_imm;
      wdata_p0 <= sel_wdata(MemSrc, MaryData, ShelleyData, RAData);
    end
  end

  // ACCESS -> RESP boundary: memory write; contents survive reset
  always_ff @(posedge clock) begin
    if (!reset && state == ACCESS && !fault_p1 && wr_p1)
      mem[addr_p1[AW-1:0]] <= wdata_p0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      out_valid <= 1'b0;
      fault     <= 1'b0;
      mem_out   <= '0;
      sp        <= SP_INIT_D;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= ACCESS;
            req_ready <= 1'b0;
          end
        end
        ACCESS: begin
          state     <= RESP;
          out_valid <= 1'b1;
          fault     <= fault_p1;
          if (fault_p1) begin
            mem_out <= '0;
          end else begin
            mem_out <= wr_p1 ? wdata_p0 : rd_data_p1;
            if (is_push_p1) sp <= sp - STEP_D;
            if (is_pop_p1)  sp <= sp + STEP_D;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          out_valid <= 1'b0;
          fault     <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          out_valid <= 1'b0;
          fault     <= 1'b0;
        end
      endcase
    end
  end

endmodule
